// File: rtl/mlp_stream_loader.sv
// rtl/mlp_stream_loader.sv - Bridge word reader that unpacks DATA_W words into an ELEM_W first-word-fall-through FIFO.
module mlp_stream_loader #(
    parameter int DATA_W     = 128,
    parameter int ADDR_W     = 26,
    parameter int ELEM_W     = 8,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [ADDR_W-1:0]               base_addr,
    input  logic [15:0]                     num_words,
    output logic [ADDR_W-1:0]               interface_address,
    output logic [DATA_W/8-1:0]             interface_byte_enable,
    output logic                            interface_read,
    input  logic [DATA_W-1:0]               interface_read_data,
    input  logic                            interface_acknowledge,
    output logic [ELEM_W-1:0]               out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            busy,
    output logic                            done
);
    localparam int EPW        = DATA_W / ELEM_W;
    localparam int WORD_BYTES = DATA_W / 8;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int IDX_W      = (EPW > 1) ? $clog2(EPW) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_REQ,
        S_UNPACK,
        S_FINISH
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic [15:0]         r_num_words;
    logic [15:0]         r_word_cnt;
    logic [DATA_W-1:0]   r_buf;
    logic [IDX_W-1:0]    r_elem_idx;
    logic [ELEM_W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_free;
    logic                w_space_ok;
    logic                w_last_elem;
    logic                w_last_word;

    assign w_push      = (r_state == S_UNPACK);
    assign w_pop       = out_valid && out_ready;
    // A pop in this cycle frees a slot before the next word's first push can land.
    assign w_free      = CNT_W'(FIFO_DEPTH) - r_count + {{PTR_W{1'b0}}, w_pop};
    assign w_space_ok  = (w_free >= CNT_W'(EPW));
    assign w_last_elem = (r_elem_idx == IDX_W'(EPW - 1));
    assign w_last_word = ((r_word_cnt + 16'd1) == r_num_words);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (start) w_next = (num_words == 16'd0) ? S_FINISH : S_WAIT_SPACE;
            S_WAIT_SPACE: if (w_space_ok) w_next = S_REQ;
            S_REQ:        if (interface_acknowledge) w_next = S_UNPACK;
            S_UNPACK:     if (w_last_elem) w_next = w_last_word ? S_FINISH : S_WAIT_SPACE;
            S_FINISH:     w_next = S_IDLE;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_num_words <= '0;
            r_word_cnt  <= '0;
            r_buf       <= '0;
            r_elem_idx  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (start) begin
                    r_base      <= base_addr;
                    r_num_words <= num_words;
                    r_word_cnt  <= '0;
                end
                S_REQ: if (interface_acknowledge) begin
                    r_buf      <= interface_read_data;
                    r_elem_idx <= '0;
                end
                S_UNPACK: begin
                    // Shift so the next element is always in the low lane.
                    r_buf      <= r_buf >> ELEM_W;
                    r_elem_idx <= r_elem_idx + IDX_W'(1);
                    if (w_last_elem) r_word_cnt <= r_word_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_buf[ELEM_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign interface_read        = (r_state == S_REQ);
    assign interface_address     = r_base + ADDR_W'(r_word_cnt) * ADDR_W'(WORD_BYTES);
    assign interface_byte_enable = '1;
    assign out_data              = r_mem[r_rd_ptr];
    assign out_valid             = (r_count != '0);
    assign fifo_count            = r_count;
    assign busy                  = (r_state != S_IDLE);
    assign done                  = (r_state == S_FINISH);
endmodule
